// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: sweeps a 4-input gate through all 16 vectors and checks its truth-table signature (TT_ERR_INDEX_EN adds first-mismatch reporting)
module tt_sweep_checker #(
  parameter logic [15:0] EXPECTED      = 16'h409B,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [3:0]  dut_in,
  input  logic        dut_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
`ifdef TT_ERR_INDEX_EN
  ,
  output logic        err_valid,
  output logic [3:0]  err_idx
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;
  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);
  state_e      state_q;
  logic [3:0]  idx_q;
  logic [3:0]  cnt_q;
  logic [15:0] sig_d;
  assign sig_d = {signature[14:0], dut_out};
  // sweep sequencer; every output is registered so dut_in only moves on capture edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      dut_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q   <= RUN;
          busy      <= 1'b1;
          idx_q     <= '0;
          dut_in    <= '0;
          cnt_q     <= RELOAD;
          signature <= '0;
          pass      <= 1'b0;
        end
        RUN: if (cnt_q != 4'd0) begin
          cnt_q <= cnt_q - 4'd1;
        end else begin
          signature <= sig_d;
          if (idx_q != 4'd15) begin
            idx_q  <= idx_q + 4'd1;
            dut_in <= idx_q + 4'd1;
            cnt_q  <= RELOAD;
          end else begin
            state_q <= FINISH;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (sig_d == EXPECTED);
            dut_in  <= '0;
          end
        end
        default: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
`ifdef TT_ERR_INDEX_EN
  logic exp_bit;
  assign exp_bit = EXPECTED[4'd15 - idx_q];
  // latch the first vector whose captured output disagrees with EXPECTED
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid <= 1'b0;
      err_idx   <= '0;
    end else if (state_q == IDLE && start) begin
      err_valid <= 1'b0;
      err_idx   <= '0;
    end else if (state_q == RUN && cnt_q == 4'd0 && !err_valid && dut_out != exp_bit) begin
      err_valid <= 1'b1;
      err_idx   <= idx_q;
    end
  end
`endif
endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb_tt_sweep_checker: scoreboard bench for tt_sweep_checker (SETTLE_CYCLES=2 and =1 instances)
module tb_tt_sweep_checker;
  localparam logic [15:0] EXP = 16'h409B;
  typedef struct {logic [15:0] sig; logic pass; int cyc;} exp_t;
  logic clk = 0, rst_n = 0, start = 0, start1 = 0;
  logic [3:0] dut_in, dut_in1;
  logic dut_out, dut_out1, busy, busy1, done, done1, pass, pass1;
  logic [15:0] signature, signature1;
`ifdef TT_ERR_INDEX_EN
  logic err_valid, err_valid1;
  logic [3:0] err_idx, err_idx1;
`endif
  int mode = 0, mode1 = 0;
  int n_tests = 0, n_fail = 0, n_done0 = 0, n_done1 = 0, busy0 = 0, busy1c = 0, d;
  exp_t q0[$], q1[$];
  exp_t e0, e1;

  always #5 clk = ~clk;

  function automatic logic gate(input int m, input logic [3:0] v);
    logic [15:0] t;
    t = EXP;
    return m == 1 ? 1'b0 : m == 2 ? ~t[4'd15 - v] : t[4'd15 - v];
  endfunction

  function automatic logic [15:0] exp_sig(input int m);
    logic [15:0] s = '0;
    for (int v = 0; v < 16; v++) s = {s[14:0], gate(m, 4'(v))};
    return s;
  endfunction

  assign dut_out  = gate(mode, dut_in);
  assign dut_out1 = gate(mode1, dut_in1);

  tt_sweep_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .signature(signature)
`ifdef TT_ERR_INDEX_EN
    , .err_valid(err_valid), .err_idx(err_idx)
`endif
  );

  tt_sweep_checker #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_in(dut_in1), .dut_out(dut_out1),
    .busy(busy1), .done(done1), .pass(pass1), .signature(signature1)
`ifdef TT_ERR_INDEX_EN
    , .err_valid(err_valid1), .err_idx(err_idx1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic push0(input int m);
    q0.push_back('{exp_sig(m), exp_sig(m) == EXP, 32});
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    if (which == 1) start1 = 1; else start = 1;
    @(negedge clk);
    start = 0;
    start1 = 0;
  endtask

  task automatic wait_done(input int which, input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(which == 1 ? done1 : done) && n < limit);
    chk("done_seen", which == 1 ? done1 : done, 1);
  endtask

  // instance 0 scoreboard: vector sequence, done timing, signature and pass
  always @(negedge clk) begin
    if (!rst_n) busy0 = 0;
    else begin
      if (busy) begin
        busy0++;
        chk("dut_in", dut_in, 32'((busy0 - 1) / 2));
      end
      if (done) begin
        chk("done_dut_in", dut_in, 0);
        if (q0.size() == 0) chk("unexp_done", 1, 0);
        else begin
          e0 = q0.pop_front();
          chk("signature", signature, e0.sig);
          chk("pass", pass, e0.pass);
          chk("busy_len", busy0, e0.cyc);
        end
        busy0 = 0;
        n_done0++;
      end
    end
  end

  // instance 1 scoreboard (one settle cycle per vector)
  always @(negedge clk) begin
    if (!rst_n) busy1c = 0;
    else begin
      if (busy1) begin
        busy1c++;
        chk("dut_in1", dut_in1, 32'(busy1c - 1));
      end
      if (done1) begin
        if (q1.size() == 0) chk("unexp_done1", 1, 0);
        else begin
          e1 = q1.pop_front();
          chk("signature1", signature1, e1.sig);
          chk("pass1", pass1, e1.pass);
          chk("busy_len1", busy1c, e1.cyc);
        end
        busy1c = 0;
        n_done1++;
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_dut_in", dut_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_sig", signature, 0);
    rst_n = 1;
    @(negedge clk);
    // correct gate
    mode = 0;
    push0(0);
    pulse(0);
    wait_done(0, 100);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    repeat (3) @(negedge clk);
    chk("pass_hold", pass, 1);
    chk("sig_hold", signature, EXP);
`ifdef TT_ERR_INDEX_EN
    chk("err_valid_good", err_valid, 0);
`endif
    // output stuck at 0
    mode = 1;
    push0(1);
    pulse(0);
    wait_done(0, 100);
`ifdef TT_ERR_INDEX_EN
    chk("err_valid_stuck", err_valid, 1);
    chk("err_idx_stuck", err_idx, 1);
`endif
    // inverted gate on the single-settle instance
    mode1 = 2;
    q1.push_back('{exp_sig(2), 1'b0, 16});
    pulse(1);
    wait_done(1, 60);
    chk("inv_sig_const", signature1, 16'hBF64);
`ifdef TT_ERR_INDEX_EN
    chk("err_valid_inv", err_valid1, 1);
    chk("err_idx_inv", err_idx1, 0);
`endif
    // start re-asserted mid-sweep is ignored
    mode = 0;
    d = n_done0;
    push0(0);
    pulse(0);
    repeat (3) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (14) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done(0, 100);
    repeat (40) @(negedge clk);
    chk("single_done", n_done0 - d, 1);
    // reset while idx=7
    push0(0);
    pulse(0);
    for (int i = 0; i < 60 && dut_in != 4'd7; i++) @(negedge clk);
    chk("reached_idx7", dut_in, 7);
    d = n_done0;
    rst_n = 0;
    #1;
    chk("mid_rst_dut_in", dut_in, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sig", signature, 0);
    q0.delete();
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (40) @(negedge clk);
    chk("no_done_after_rst", n_done0 - d, 0);
    push0(0);
    pulse(0);
    wait_done(0, 100);
    // start held high: back-to-back sweeps with one idle cycle
    push0(0);
    push0(0);
    @(negedge clk);
    start = 1;
    wait_done(0, 100);
    @(negedge clk);
    chk("idle_gap", busy, 0);
    @(negedge clk);
    chk("restart", busy, 1);
    wait_done(0, 100);
    start = 0;
    repeat (40) @(negedge clk);
    chk("queue_empty", q0.size(), 0);
    chk("queue1_empty", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
- Sequential stimulus/response stage wrapped around a 4-input, 1-output combinational gate netlist.
- Drives all 16 input vectors into the gate in order and shifts each gate output into a 16-bit truth-table signature.
- Compares the signature against the expected function code (default 0x409B).
- Used for post-synthesis equivalence spot checks of the generated gate designs.

Parameters:
EXPECTED, 16'h409B, expected truth-table code, MSB = vector index 0
SETTLE_CYCLES, 2, clocks each vector is held before the output is sampled; legal range 1..15

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  sweep request, sampled only in IDLE
dut_in  output  4  gate inputs: dut_in[3] to gate input _0, [2] to _1, [1] to _2, [0] to _3
dut_out  input  1  gate output _4, combinational from dut_in
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse when the sweep completes
pass  output  1  signature == EXPECTED; valid from done onward, held until next start
signature  output  16  captured truth table, held after completion

Behaviour:
- Reset (async assert, sync-style deassert handled by the flop): state=IDLE; dut_in=0, busy=0, done=0, pass=0, signature=0, idx=0, settle counter=0.
- States: IDLE, RUN, FINISH.
- IDLE
  - start=1 at edge E0 -> RUN; busy=1; idx=0; dut_in=0; settle counter=SETTLE_CYCLES-1; signature cleared to 0; pass cleared to 0.
  - start=0 -> stay in IDLE; all outputs hold.
- RUN
  - Settle counter nonzero -> decrement it.
  - Settle counter zero -> signature <= {signature[14:0], dut_out}.
  - If idx<15 on that capture: idx+1; dut_in=idx+1; counter reloads to SETTLE_CYCLES-1.
  - If idx==15 on that capture -> FINISH.
- Capture timing: vector k is sampled at edge E0+(k+1)*SETTLE_CYCLES. The final capture is at E0+16*SETTLE_CYCLES.
- FINISH (exactly one cycle)
  - done=1; busy=0; pass = (signature == EXPECTED); dut_in returns to 0; next state IDLE.
  - done is high in the cycle following the final capture edge.
- Signature ordering: vector 0 ends at bit 15 and vector 15 at bit 0. A correct gate yields signature 0x409B.
- start is ignored in RUN and FINISH; no queuing. Holding start high continuously gives one IDLE cycle between sweeps.
- dut_in is registered and changes only at capture edges, so the gate always has at least SETTLE_CYCLES full clocks to settle.
- idx wraps only through FINISH/IDLE, never within RUN.
- Reset asserted mid-sweep: immediate return to reset values. No partial signature is retained and no done pulse is emitted.
- X on dut_out is captured as-is. pass is then not guaranteed; the bench treats it as a failure.

Optional Feature:
TT_ERR_INDEX_EN
- Defined: adds outputs err_valid (1 bit) and err_idx (4 bits), both reset to 0 and cleared on start.
  - At each capture, if dut_out != EXPECTED[15-idx] and err_valid==0, then err_valid=1 and err_idx=idx.
  - Both hold until the next start or reset.
  - The sweep still runs to completion; there is no early abort.
- Not defined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Correct gate, SETTLE_CYCLES=2, start pulse at E0 -> signature=0x409B, pass=1, done high exactly one cycle after edge E0+32, busy high for 32 cycles.
- dut_out stuck at 0 -> signature=0x0000, pass=0; with TT_ERR_INDEX_EN: err_valid=1, err_idx=1.
- Inverted gate output, SETTLE_CYCLES=1 -> signature=0xBF64, pass=0, done after edge E0+16; with TT_ERR_INDEX_EN: err_idx=0.
- start re-asserted at cycles 5 and 20 of a running sweep -> ignored; single done pulse; signature=0x409B.
- rst_n low while idx=7 -> dut_in=0, busy=0, signature=0, no done. A new start then gives a full clean sweep with pass=1.
- start held high continuously -> done pulses, one IDLE cycle, next sweep begins; dut_in sequence 0..15 repeats; each pass=1.
